uart_tx_fifo: RTL and testbench

Transmit-side byte buffer placed directly upstream of the UART transmitter. It accepts bytes from the system side as single-cycle write strobes and stores up to 2^DEPTH_LOG2 of them. It issues them one at a time to the transmitter through a start-pulse and busy handshake. Producers can burst bytes faster than the line rate without losing data.

---
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the system-side producer, the transmit FIFO and the UART transmitter.
// The master modport is the environment (producer plus transmitter); the slave modport is the FIFO.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8
);
    logic                  wr_en;
    logic [WIDTH-1:0]      wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  tx_start;
    logic [WIDTH-1:0]      tx_data;
    logic                  tx_busy;
    logic                  ovf_clr;
    logic                  overflow;

    modport master (
        output wr_en, wr_data, tx_busy, ovf_clr,
        input  full, empty, count, tx_start, tx_data, overflow
    );

    modport slave (
        input  wr_en, wr_data, tx_busy, ovf_clr,
        output full, empty, count, tx_start, tx_data, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding a UART transmitter through a start-pulse / busy handshake.
// Optional sticky overflow flag is enabled by defining UART_TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8
) (
    input  logic           CP,
    input  logic           RST,
    uart_tx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                state;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  full_r;
    logic                  empty_r;
    logic                  tx_start_r;
    logic [WIDTH-1:0]      tx_data_r;
    logic [1:0]            wait_cnt;
    logic                  wr_acc;
    logic                  pop;

    // A write into a full buffer is rejected even when a pop frees a slot on the same edge.
    always_comb begin
        wr_acc    = bus.wr_en && !full_r;
        pop       = (state == IDLE) && (count != '0) && !bus.tx_busy;
        count_nxt = count;
        if (wr_acc && !pop)
            count_nxt = count + 1'b1;
        else if (!wr_acc && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge CP) begin
        if (RST && wr_acc)
            mem[wptr] <= bus.wr_data;
    end

    always_ff @(posedge CP) begin
        if (!RST) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
            wait_cnt   <= '0;
            state      <= IDLE;
        end else begin
            if (wr_acc)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            count   <= count_nxt;
            full_r  <= (count_nxt == FULL_CNT);
            empty_r <= (count_nxt == '0);

            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data_r  <= mem[rptr];
                        tx_start_r <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_start_r <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A transmitter that never acknowledges still lets the queue move on.
                    if (bus.tx_busy)
                        state <= WAIT_DONE;
                    else if (wait_cnt == 2'd3)
                        state <= IDLE;
                    else
                        wait_cnt <= wait_cnt + 2'd1;
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic overflow_r;

    // Setting wins over clearing so a rejected write is never lost.
    always_ff @(posedge CP) begin
        if (!RST)
            overflow_r <= 1'b0;
        else if (bus.wr_en && full_r)
            overflow_r <= 1'b1;
        else if (bus.ovf_clr)
            overflow_r <= 1'b0;
    end

    assign bus.overflow = overflow_r;
`else
    // ovf_clr has no effect in this build; the flag is tied low.
    assign bus.overflow = bus.ovf_clr & 1'b0;
`endif

    assign bus.full     = full_r;
    assign bus.empty    = empty_r;
    assign bus.count    = count;
    assign bus.tx_start = tx_start_r;
    assign bus.tx_data  = tx_data_r;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized scoreboard bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;
    localparam int DL    = 3;
    localparam int W     = 8;
    localparam int DEPTH = 1 << DL;

    logic CP;
    logic RST;

    uart_tx_fifo_if #(.DEPTH_LOG2(DL), .WIDTH(W)) bus ();

    uart_tx_fifo #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
        .CP  (CP),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    int checks = 0;
    int errors = 0;

    // Reference model: stored bytes, one in-flight byte, expected tx_data stream
    logic [W-1:0] q[$];
    logic [W-1:0] exp_q[$];
    bit           inflight = 0;
    int           age      = 0;
    bit           seen     = 0;
    bit           m_pulse  = 0;
    bit           m_ovf    = 0;

    // Transmitter model
    int mode     = 0;   // 0 react after tx_start, 1 hold busy high, 2 hold busy low
    int busy_len = 10;
    bit pending  = 0;
    int left     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int sz;
        sz = q.size();
        m_pulse = 0;
        if (!RST) begin
            q.delete();
            exp_q.delete();
            inflight = 0;
            m_ovf    = 0;
            return;
        end
        if (!inflight) begin
            if (sz > 0 && !bus.tx_busy) begin
                exp_q.push_back(q.pop_front());
                inflight = 1;
                age      = 0;
                seen     = 0;
                m_pulse  = 1;
            end
        end else begin
            age++;
            if (age >= 2) begin
                if (seen) begin
                    if (!bus.tx_busy) inflight = 0;
                end else if (bus.tx_busy) begin
                    seen = 1;
                end else if (age == 5) begin
                    inflight = 0;
                end
            end
        end
        if (bus.wr_en) begin
            if (sz < DEPTH) q.push_back(bus.wr_data);
`ifdef UART_TX_FIFO_OVERFLOW_EN
            else m_ovf = 1;
`endif
        end
`ifdef UART_TX_FIFO_OVERFLOW_EN
        if (!(bus.wr_en && sz >= DEPTH) && bus.ovf_clr) m_ovf = 0;
`endif
    endtask

    task automatic set_mode(input int m);
        mode    = m;
        pending = 0;
        left    = 0;
        bus.tx_busy = (m == 1);
    endtask

    task automatic tick();
        bit was_rst;
        was_rst = !RST;
        model_step();
        @(posedge CP);
        #1;
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
        chk("tx_start", 32'(bus.tx_start), 32'(m_pulse));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        if (was_rst) chk("tx_data_rst", 32'(bus.tx_data), 32'h0);
        if (mode == 0) begin
            if (m_pulse) begin
                pending = 1;
            end else if (pending) begin
                pending     = 0;
                bus.tx_busy = 1'b1;
                left        = busy_len;
            end else if (left > 0) begin
                left--;
                if (left == 0) bus.tx_busy = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    always @(negedge CP) begin
        if (bus.tx_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected actual=%0h expected=none time=%0t", bus.tx_data, $time);
            end else begin
                chk("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bit reached;
        RST         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.ovf_clr = 1'b0;
        set_mode(0);

        idle(2);
        RST = 1'b1;
        idle(2);

        // single byte with a transmitter acknowledging one cycle after the pulse
        busy_len = 10;
        wr(8'h42);
        idle(25);

        // fill while the transmitter stays busy, then one rejected write
        set_mode(1);
        for (int i = 1; i <= 8; i++) wr(8'(i));
        wr(8'h09);
        idle(1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        idle(1);

        // drain in write order
        busy_len = 3;
        set_mode(0);
        idle(100);

        // stream across the pointer wrap with random gaps
        busy_len = 2;
        for (int i = 0; i < 12; i++) begin
            wr(8'(8'h10 + i));
            idle($urandom_range(0, 3));
        end
        idle(100);

        // transmitter never acknowledges
        set_mode(2);
        wr(8'h23);
        wr(8'h24);
        idle(30);

        // reset while a frame is in progress
        busy_len = 10;
        set_mode(0);
        wr(8'h55);
        wr(8'h66);
        wr(8'h77);
        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (inflight && seen && age >= 3) reached = 1;
            else tick();
        end
        chk("reach_wait_done", 32'(reached), 32'h1);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        idle(40);

        // randomized traffic
        for (int blk = 0; blk < 6; blk++) begin
            busy_len = $urandom_range(1, 6);
            set_mode($urandom_range(0, 2));
            for (int i = 0; i < 50; i++) begin
                bus.wr_en   = ($urandom_range(0, 2) != 0);
                bus.wr_data = 8'($urandom);
                bus.ovf_clr = ($urandom_range(0, 9) == 0);
                tick();
            end
        end
        bus.wr_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        busy_len    = 2;
        set_mode(0);
        idle(120);
        chk("drained_model", 32'(q.size()), 32'h0);
        chk("drained_pulses", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
